// File: rtl/locker_pkg.sv
// Shared types and constants for the parcel-locker opening scheduler.
package locker_pkg;

  localparam int         NUM_LOCKERS = 8;
  localparam int         IDX_W       = 3;
  localparam logic [3:0] IDLE_IDX    = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/locker_req_fifo.sv
// Small synchronous request FIFO with combinational head; push is ignored when full,
// pop is ignored when empty.
module locker_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk_2,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk_2) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/locker_open_sched.sv
// Locker opening scheduler: arbitrates keypad (A) and admin (B) requests, queues them,
// and sequences taking/playing one locker at a time. LOCKER_ADMIN_PRIO_EN gives B fixed priority.
//
// state  | meaning
// IDLE   | taking=F; pops the FIFO head when one is queued
// OPEN   | taking=idx, playing=1 for ANIM_CYCLES cycles
// COMMIT | taking=idx, playing=0, done pulses; indicator clears full[idx]
module locker_open_sched
  import locker_pkg::*;
#(
  parameter int NUM_LOCKERS = locker_pkg::NUM_LOCKERS,
  parameter int FIFO_DEPTH  = 4,
  parameter int ANIM_CYCLES = 6
) (
  input  logic                   clk_2,
  input  logic                   rst,
  input  logic                   req_valid_a,
  input  logic [IDX_W-1:0]       req_idx_a,
  output logic                   req_ready_a,
  input  logic                   req_valid_b,
  input  logic [IDX_W-1:0]       req_idx_b,
  output logic                   req_ready_b,
  input  logic [NUM_LOCKERS-1:0] full,
  output logic [3:0]             taking,
  output logic                   playing,
  output logic                   rej_a,
  output logic                   rej_b,
  output logic                   done,
  output logic                   busy
);

  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic [IDX_W-1:0]       cur_idx;
  logic [NUM_LOCKERS-1:0] pend;
  logic                   pri_b;
  logic                   fifo_full, fifo_empty, pop, push;
  logic [IDX_W-1:0]       head, push_idx;
  logic                   hs_a, hs_b, acc_a, acc_b;

`ifdef LOCKER_ADMIN_PRIO_EN
  assign pri_b = 1'b1;
`else
  // Round-robin: the port granted last loses the next tie; reset favours A.
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst)      pri_b <= 1'b0;
    else if (hs_a) pri_b <= 1'b1;
    else if (hs_b) pri_b <= 1'b0;
  end
`endif

  // Ready uses the pre-pop FIFO state, so a full FIFO stalls even on its pop cycle.
  assign hs_a = rst && !fifo_full && req_valid_a && (!req_valid_b || !pri_b);
  assign hs_b = rst && !fifo_full && req_valid_b && (!req_valid_a || pri_b);
  assign req_ready_a = hs_a;
  assign req_ready_b = hs_b;

  assign acc_a    = full[req_idx_a] && !pend[req_idx_a];
  assign acc_b    = full[req_idx_b] && !pend[req_idx_b];
  assign push     = (hs_a && acc_a) || (hs_b && acc_b);
  assign push_idx = hs_b ? req_idx_b : req_idx_a;

  locker_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IDX_W)
  ) u_fifo (
    .clk_2 (clk_2),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_idx),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pending covers queued entries and the locker in flight until its commit.
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      pend  <= '0;
      rej_a <= 1'b0;
      rej_b <= 1'b0;
    end else begin
      if (state == COMMIT) pend[cur_idx]  <= 1'b0;
      if (push)            pend[push_idx] <= 1'b1;
      rej_a <= hs_a && !acc_a;
      rej_b <= hs_b && !acc_b;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = OPEN;
          cnt_nxt   = 8'(ANIM_CYCLES - 1);
        end
      end
      OPEN: begin
        if (cnt == 8'd0) state_nxt = COMMIT;
        else             cnt_nxt   = cnt - 8'd1;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_idx <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pop) cur_idx <= head;
    end
  end

  assign taking  = (state == IDLE) ? IDLE_IDX : {{(4-IDX_W){1'b0}}, cur_idx};
  assign playing = (state == OPEN);
  assign done    = (state == COMMIT);
  assign busy    = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_locker_open_sched.sv
// Self-checking bench for locker_open_sched: vector table plus hand-written corner sequences,
// with a scoreboard of expected opening order checked on every done pulse.
module tb_locker_open_sched;
  import locker_pkg::*;

  localparam int ANIM = 6;
`ifdef LOCKER_ADMIN_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk_2 = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic [2:0] req_idx_a = '0, req_idx_b = '0;
  logic       req_ready_a, req_ready_b;
  logic [7:0] full = 8'hFF;
  logic [3:0] taking;
  logic       playing, rej_a, rej_b, done, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc[$];
  logic [3:0] exp_q[$];

  typedef struct {
    bit         pb;
    logic [2:0] idx;
    logic [7:0] fmap;
    bit         rej;
  } vec_t;
  vec_t vecs[6];

  locker_open_sched #(.NUM_LOCKERS(8), .FIFO_DEPTH(4), .ANIM_CYCLES(ANIM)) dut (
    .clk_2       (clk_2),
    .rst         (rst),
    .req_valid_a (req_valid_a),
    .req_idx_a   (req_idx_a),
    .req_ready_a (req_ready_a),
    .req_valid_b (req_valid_b),
    .req_idx_b   (req_idx_b),
    .req_ready_b (req_ready_b),
    .full        (full),
    .taking      (taking),
    .playing     (playing),
    .rej_a       (rej_a),
    .rej_b       (rej_b),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk_2 = ~clk_2;
  always @(posedge clk_2) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every committed opening must match the next expected locker.
  always @(negedge clk_2) begin
    if (rst && done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL commit_unexpected: got taking=%0d expected no commit", taking);
      end else begin
        check("commit_idx", taking, exp_q.pop_front());
      end
      check("commit_playing", playing, 0);
    end
  end

  task automatic req(input bit pb, input logic [2:0] idx, output int stall);
    stall = 0;
    @(negedge clk_2);
    if (pb) begin req_valid_b = 1'b1; req_idx_b = idx; end
    else    begin req_valid_a = 1'b1; req_idx_a = idx; end
    #1;
    while (!(pb ? req_ready_b : req_ready_a) && stall < 200) begin
      @(negedge clk_2);
      #1;
      stall++;
    end
    if (stall >= 200) check("req_timeout", stall, 0);
    @(posedge clk_2);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_2);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk_2);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_playing();
    int n = 0;
    while (playing !== 1'b1 && n < 20) begin
      @(negedge clk_2);
      n++;
    end
    check("playing_timeout", playing, 1);
  endtask

  task automatic do_reset();
    @(negedge clk_2);
    rst = 1'b0;
    repeat (2) @(negedge clk_2);
    rst = 1'b1;
  endtask

  initial begin
    int st;
    int base;
    vecs[0] = '{1'b0, 3'd2, 8'hFB, 1'b1};
    vecs[1] = '{1'b0, 3'd4, 8'h10, 1'b0};
    vecs[2] = '{1'b1, 3'd7, 8'h80, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 8'hFE, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 8'h01, 1'b0};
    vecs[5] = '{1'b1, 3'd5, 8'hDF, 1'b1};

    // Reset values, with a valid request present to show ready stays low.
    req_valid_a = 1'b1;
    #1;
    check("rst_taking", taking, 4'hF);
    check("rst_playing", playing, 0);
    check("rst_ready_a", req_ready_a, 0);
    check("rst_ready_b", req_ready_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rej", {rej_a, rej_b}, 0);
    req_valid_a = 1'b0;
    repeat (2) @(negedge clk_2);
    rst = 1'b1;

    // Single opening: exact playing window and commit timing.
    full = 8'hFF;
    req(1'b0, 3'd3, st);
    exp_q.push_back(4'd3);
    @(negedge clk_2);
    check("t1_pop_cycle_taking", taking, 4'hF);
    for (int i = 0; i < ANIM; i++) begin
      @(negedge clk_2);
      check("t1_open_playing", playing, 1);
      check("t1_open_taking", taking, 4'd3);
    end
    @(negedge clk_2);
    check("t1_commit_done", done, 1);
    check("t1_commit_taking", taking, 4'd3);
    @(negedge clk_2);
    check("t1_idle_taking", taking, 4'hF);
    check("t1_idle_done", done, 0);
    check("t1_idle_busy", busy, 0);

    // Table: accept/reject by occupancy on either port.
    for (int v = 0; v < 6; v++) begin
      full = vecs[v].fmap;
      req(vecs[v].pb, vecs[v].idx, st);
      if (!vecs[v].rej) exp_q.push_back({1'b0, vecs[v].idx});
      @(negedge clk_2);
      check("vec_rej_own", vecs[v].pb ? rej_b : rej_a, vecs[v].rej);
      check("vec_rej_other", vecs[v].pb ? rej_a : rej_b, 0);
      check("vec_busy", busy, !vecs[v].rej);
      wait_idle();
    end

    // Tie between A (idx 1) and B (idx 5) on two consecutive cycles.
    do_reset();
    full = 8'hFF;
    @(negedge clk_2);
    req_valid_a = 1'b1; req_idx_a = 3'd1;
    req_valid_b = 1'b1; req_idx_b = 3'd5;
    #1;
    check("tie1_ready_a", req_ready_a, !PRIO);
    check("tie1_ready_b", req_ready_b, PRIO);
    @(posedge clk_2);
    #1;
    check("tie2_ready_a", req_ready_a, 0);
    check("tie2_ready_b", req_ready_b, 1);
    @(posedge clk_2);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    if (PRIO) exp_q.push_back(4'd5);
    else begin exp_q.push_back(4'd1); exp_q.push_back(4'd5); end
    @(negedge clk_2);
    check("tie2_rej_b", rej_b, PRIO);
    check("tie2_rej_a", rej_a, 0);
    wait_idle();

    // Flood B: FIFO fills behind the first opening; the last request stalls.
    done_cyc.delete();
    full = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      req(1'b1, 3'(i), st);
      exp_q.push_back(4'(i));
      check("flood_stall", st, (i == 5) ? 5 : 0);
    end
    wait_idle();
    check("flood_commits", done_cyc.size(), 6);
    for (int k = 1; k < done_cyc.size(); k++)
      check("flood_gap", done_cyc[k] - done_cyc[k-1], ANIM + 2);

    // Duplicate request while its locker is opening.
    base = done_cnt;
    req(1'b1, 3'd6, st);
    exp_q.push_back(4'd6);
    wait_playing();
    req(1'b1, 3'd6, st);
    @(negedge clk_2);
    check("dup_rej_b", rej_b, 1);
    wait_idle();
    check("dup_done_count", done_cnt - base, 1);

    // Reset in the middle of OPEN abandons the opening.
    base = done_cnt;
    req(1'b0, 3'd7, st);
    exp_q.push_back(4'd7);
    wait_playing();
    repeat (2) @(negedge clk_2);
    rst = 1'b0;
    #1;
    check("mid_rst_taking", taking, 4'hF);
    check("mid_rst_playing", playing, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk_2);
    rst = 1'b1;
    repeat (12) @(negedge clk_2);
    check("mid_rst_no_done", done_cnt - base, 0);
    check("mid_rst_busy_after", busy, 0);
    // Pending bit must have been cleared by reset.
    req(1'b0, 3'd7, st);
    exp_q.push_back(4'd7);
    @(negedge clk_2);
    check("post_rst_rej_a", rej_a, 0);
    wait_idle();
    check("post_rst_done", done_cnt - base, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
